dm_bridge: RTL and testbench
============================

# dm_bridge

Data-side responder for the mini_rv pipeline core: it serves the core's MEM-stage data port (address, write data, write enable; read data returned combinationally). It decodes each access to either the external data RAM or a small memory-mapped I/O region. The I/O region holds LEDs, switches, buttons, an 8-digit seven-segment display and a free-running timer. It sits between the core and the DRAM / board pins in the SoC top.

## Interface
- SCAN_DIV, 50000: clk cycles each display digit is lit (≥2).
- DRAM_AW, 14: DRAM word-address width.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- addr_i  in  32  byte address (core ALU result, MEM stage)
- wdata_i  in  32  store data
- we_i  in  1  1 = write, 0 = read
- rdata_o  out  32  read data, combinational, same cycle
- dram_addr_o  out  DRAM_AW  word address = addr_i[DRAM_AW+1:2]
- dram_wdata_o  out  32  = wdata_i
- dram_we_o  out  1  DRAM write strobe
- dram_rdata_i  in  32  DRAM asynchronous read data
- sw_i  in  24  board switches, asynchronous
- btn_i  in  5  board buttons, asynchronous
- led_o  out  24  LED register
- dig_en_o  out  8  digit enables, active-low
- seg_o  out  8  {DP,G,F,E,D,C,B,A}, active-low

## Operation
- io_sel = (addr_i[31:12] == 20'hFFFFF). Otherwise the access goes to DRAM.
- dram_we_o = we_i & ~io_sel & ~rst. In DRAM mode, rdata_o = dram_rdata_i.
- Word access only; addr_i[1:0] ignored. I/O offset = addr_i[11:0] with [1:0] masked.
- I/O map:
  - 0x000 DISP: RW, 8 hex nibbles, nibble 0 = rightmost digit.
  - 0x020 TCNT: RW; a write loads the count.
  - 0x024 TPRE: RW, prescale.
  - 0x060 LED: RW, bits[23:0]; reads return zero-extended value.
  - 0x070 SW: RO, {8'h0, sw_sync}.
  - 0x078 BTN: RO, {27'h0, btn_sync}.
  - Other offsets: read 0, writes ignored. Writes to RO offsets are ignored.
- sw_i and btn_i pass through two-flop synchronizers. SW and BTN reads return the synchronized value.
- Timer:
  - pcnt increments each cycle. When pcnt == TPRE, pcnt←0 and TCNT←TCNT+1.
  - TPRE=0 means TCNT increments every cycle.
  - TCNT wraps 0xFFFFFFFF→0.
  - A TCNT write loads wdata_i and clears pcnt. The write wins over a same-cycle increment.
  - A TPRE write clears pcnt.
- Display scan:
  - scnt counts 0..SCAN_DIV-1. At terminal count, scnt←0 and idx←idx+1 (3-bit, 7→0 wraps).
  - dig_en_o ← ~(8'b1 << idx), registered.
  - seg_o ← {1'b1, ~hex7(DISP[4*idx+:4])}, registered, with DP off.
  - hex7 is active-high {G..A}: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.

## Timing
- Reads are combinational: rdata_o is valid in the same cycle as addr_i. The core's load forwarding depends on this.
- Writes commit on the rising edge where we_i=1. A same-cycle read returns the old value; the next cycle returns the new value.
- Switch/button: an input change is visible on reads 2 cycles later.
- seg_o / dig_en_o lag idx or DISP changes by 1 cycle. A DISP write is visible on the pins 1 cycle after commit, if that digit is active.
- Reset values:
  - DISP, LED, TCNT, TPRE, pcnt, scnt, idx, sync flops = 0.
  - dig_en_o = 8'hFF, seg_o = 8'hFF.
  - First cycle after rst falls: dig_en_o = FE, seg_o = C0.
- Reset asserted mid-operation: all of the above registers return to reset values on that edge, and the write is suppressed (both I/O and DRAM).

## Structure
- Shared package `dm_bridge_pkg`: IO_BASE (20'hFFFFF), offset constants (OFF_DISP, OFF_TCNT, OFF_TPRE, OFF_LED, OFF_SW, OFF_BTN), hex7 decode function.
- Sub-module `seg_scan`: scan counter, idx, hex decode, and registered dig_en_o/seg_o. Its inputs are DISP and SCAN_DIV.
- Top: address decode, read mux, register file, timer, synchronizers.

## Test plan
- DRAM round trip: write 0x1234ABCD to 0x0000_0010, then read it back. Required: dram_we_o pulses once with dram_addr_o=4; rdata_o=0x1234ABCD. Reading 0xFFFFF004 returns 0.
- LED/SW:
  - Write 0xFFFFFFFF to 0xFFFFF060 → led_o=0xFFFFFF, read=0x00FFFFFF, dram_we_o stays 0.
  - Set sw_i=0xA5A5A5 → reading 0xFFFFF070 returns 0x00A5A5A5 from the 2nd cycle onward.
- Timer:
  - TPRE=3, TCNT=0 → TCNT reads 1 after 4 cycles and 2 after 8 cycles.
  - Load TCNT=0xFFFFFFFF with TPRE=0 → reads 0 one cycle later.
  - TCNT write coincident with an increment → the loaded value holds.
- Display (SCAN_DIV=2):
  - Write DISP=0x76543210 → dig_en_o steps FE,FD,…,7F and wraps to FE every 2 cycles.
  - seg_o sequence: C0,F9,A4,B0,99,92,82,F8.
- Reset mid-run: assert rst during an LED write with the timer running → led_o=0, TCNT=0, dig_en_o=FF, seg_o=FF. The next cycle shows FE/C0.
- Same-cycle read/write: write DISP=0x1 while reading DISP → rdata_o shows the old value that cycle and 0x1 the next cycle.

Source files
------------

// File: rtl/dm_bridge_pkg.sv
// Shared constants and helpers for the data-side bridge: I/O window base,
// register offsets and the seven-segment hex decoder.
package dm_bridge_pkg;

    localparam logic [19:0] IO_BASE  = 20'hFFFFF;

    localparam logic [11:0] OFF_DISP = 12'h000;
    localparam logic [11:0] OFF_TCNT = 12'h020;
    localparam logic [11:0] OFF_TPRE = 12'h024;
    localparam logic [11:0] OFF_LED  = 12'h060;
    localparam logic [11:0] OFF_SW   = 12'h070;
    localparam logic [11:0] OFF_BTN  = 12'h078;

    // Active-high {G,F,E,D,C,B,A} pattern for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexed 8-digit seven-segment scanner: one digit lit for SCAN_DIV
// cycles at a time, pin outputs registered one cycle behind idx/disp.
module seg_scan
    import dm_bridge_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp,
    output logic [7:0]  dig_en_o,
    output logic [7:0]  seg_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] scnt;
    logic [2:0]    idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt     <= '0;
            idx      <= '0;
            dig_en_o <= 8'hFF;
            seg_o    <= 8'hFF;
        end else begin
            if (scnt == CW'(SCAN_DIV - 1)) begin
                scnt <= '0;
                idx  <= idx + 3'd1;
            end else begin
                scnt <= scnt + 1'b1;
            end
            // Pins are active-low; decimal point kept dark.
            dig_en_o <= ~(8'b1 << idx);
            seg_o    <= {1'b1, ~hex7(disp[{idx, 2'b00} +: 4])};
        end
    end

endmodule

// File: rtl/dm_bridge.sv
// MEM-stage data responder: routes word accesses to external DRAM or to the
// memory-mapped I/O block (display, timer, LEDs, switches, buttons).
module dm_bridge
    import dm_bridge_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DRAM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    input  logic               we_i,
    output logic [31:0]        rdata_o,
    output logic [DRAM_AW-1:0] dram_addr_o,
    output logic [31:0]        dram_wdata_o,
    output logic               dram_we_o,
    input  logic [31:0]        dram_rdata_i,
    input  logic [23:0]        sw_i,
    input  logic [4:0]         btn_i,
    output logic [23:0]        led_o,
    output logic [7:0]         dig_en_o,
    output logic [7:0]         seg_o
);

    logic        io_sel;
    logic        io_we;
    logic [11:0] off;

    logic [31:0] disp;
    logic [31:0] tcnt;
    logic [31:0] tpre;
    logic [31:0] pcnt;
    logic [23:0] sw_s1, sw_s2;
    logic [4:0]  btn_s1, btn_s2;
    logic [31:0] rd_io;

    logic unused_bits;
    assign unused_bits = ^addr_i[1:0];

    assign io_sel = (addr_i[31:12] == IO_BASE);
    assign io_we  = we_i & io_sel;
    assign off    = {addr_i[11:2], 2'b00};

    assign dram_addr_o  = addr_i[DRAM_AW+1:2];
    assign dram_wdata_o = wdata_i;
    assign dram_we_o    = we_i & ~io_sel & ~rst;

    always_comb begin
        rd_io = '0;
        case (off)
            OFF_DISP: rd_io = disp;
            OFF_TCNT: rd_io = tcnt;
            OFF_TPRE: rd_io = tpre;
            OFF_LED:  rd_io = {8'h0, led_o};
            OFF_SW:   rd_io = {8'h0, sw_s2};
            OFF_BTN:  rd_io = {27'h0, btn_s2};
            default:  rd_io = '0;
        endcase
        rdata_o = io_sel ? rd_io : dram_rdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp   <= '0;
            led_o  <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            sw_s1  <= sw_i;
            sw_s2  <= sw_s1;
            btn_s1 <= btn_i;
            btn_s2 <= btn_s1;
            if (io_we && off == OFF_DISP) disp  <= wdata_i;
            if (io_we && off == OFF_LED)  led_o <= wdata_i[23:0];
        end
    end

    // Later assignments override the free-running update, so software writes
    // win over a coincident prescaler roll-over.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
            tpre <= '0;
            pcnt <= '0;
        end else begin
            if (pcnt == tpre) begin
                pcnt <= '0;
                tcnt <= tcnt + 32'd1;
            end else begin
                pcnt <= pcnt + 32'd1;
            end
            if (io_we && off == OFF_TPRE) begin
                tpre <= wdata_i;
                pcnt <= '0;
            end
            if (io_we && off == OFF_TCNT) begin
                tcnt <= wdata_i;
                pcnt <= '0;
            end
        end
    end

    seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk      (clk),
        .rst      (rst),
        .disp     (disp),
        .dig_en_o (dig_en_o),
        .seg_o    (seg_o)
    );

endmodule

// File: tb/tb_dm_bridge.sv
// Directed bench for dm_bridge with a small behavioural DRAM model.
module tb_dm_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i, wdata_i, rdata_o, dram_wdata_o, dram_rdata_i;
    logic        we_i, dram_we_o;
    logic [13:0] dram_addr_o;
    logic [23:0] sw_i, led_o;
    logic [4:0]  btn_i;
    logic [7:0]  dig_en_o, seg_o;

    int total = 0;
    int bad   = 0;
    int dram_pulses = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    dm_bridge #(.SCAN_DIV(2), .DRAM_AW(14)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .we_i         (we_i),
        .rdata_o      (rdata_o),
        .dram_addr_o  (dram_addr_o),
        .dram_wdata_o (dram_wdata_o),
        .dram_we_o    (dram_we_o),
        .dram_rdata_i (dram_rdata_i),
        .sw_i         (sw_i),
        .btn_i        (btn_i),
        .led_o        (led_o),
        .dig_en_o     (dig_en_o),
        .seg_o        (seg_o)
    );

    assign dram_rdata_i = mem[dram_addr_o[7:0]];

    always @(posedge clk) begin
        if (dram_we_o) begin
            mem[dram_addr_o[7:0]] <= dram_wdata_o;
            dram_pulses <= dram_pulses + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_wr(input logic [31:0] a, input logic [31:0] d);
        addr_i  = a;
        wdata_i = d;
        we_i    = 1'b1;
        tick(1);
        we_i    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr_i = a;
        #1;
        v = rdata_o;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  prev, ed;
        logic        found;
        logic [7:0]  exp_seg [8];
        exp_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
        for (int i = 0; i < 256; i++) mem[i] = '0;

        rst = 1'b1; we_i = 1'b0; addr_i = '0; wdata_i = '0; sw_i = '0; btn_i = '0;
        tick(2);
        chk("rst_dig", dig_en_o, 8'hFF);
        chk("rst_seg", seg_o, 8'hFF);
        chk("rst_led", led_o, 0);
        rd(32'hFFFFF020, v); chk("rst_tcnt", v, 0);
        rst = 1'b0;
        tick(1);
        chk("post_rst_dig", dig_en_o, 8'hFE);
        chk("post_rst_seg", seg_o, 8'hC0);

        // DRAM round trip
        addr_i = 32'h10; wdata_i = 32'h1234ABCD; we_i = 1'b1;
        #1;
        chk("dram_we", dram_we_o, 1);
        chk("dram_addr", dram_addr_o, 4);
        tick(1);
        we_i = 1'b0;
        rd(32'h10, v); chk("dram_rd", v, 32'h1234ABCD);
        chk("dram_pulses", dram_pulses, 1);
        rd(32'hFFFFF004, v); chk("unmapped_rd", v, 0);

        // LED
        addr_i = 32'hFFFFF060; wdata_i = 32'hFFFFFFFF; we_i = 1'b1;
        #1;
        chk("led_no_dram_we", dram_we_o, 0);
        tick(1);
        we_i = 1'b0;
        chk("led_pins", led_o, 32'h00FFFFFF);
        rd(32'hFFFFF060, v); chk("led_rd", v, 32'h00FFFFFF);
        chk("led_dram_pulses", dram_pulses, 1);

        // Switch / button synchronizers
        sw_i = 24'hA5A5A5; btn_i = 5'h13;
        rd(32'hFFFFF070, v); chk("sw_0cyc", v, 0);
        tick(1);
        rd(32'hFFFFF070, v); chk("sw_1cyc", v, 0);
        tick(1);
        rd(32'hFFFFF070, v); chk("sw_2cyc", v, 32'h00A5A5A5);
        rd(32'hFFFFF078, v); chk("btn_2cyc", v, 32'h13);
        tick(1);
        rd(32'hFFFFF070, v); chk("sw_3cyc", v, 32'h00A5A5A5);

        // Ignored writes
        io_wr(32'hFFFFF004, 32'hDEADBEEF);
        rd(32'hFFFFF004, v); chk("unmapped_wr", v, 0);
        io_wr(32'hFFFFF070, 32'h0);
        rd(32'hFFFFF070, v); chk("ro_wr", v, 32'h00A5A5A5);

        // Timer prescale
        io_wr(32'hFFFFF024, 3);
        io_wr(32'hFFFFF020, 0);
        rd(32'hFFFFF024, v); chk("tpre_rd", v, 3);
        rd(32'hFFFFF020, v); chk("tcnt_0", v, 0);
        tick(3);
        rd(32'hFFFFF020, v); chk("tcnt_3cyc", v, 0);
        tick(1);
        rd(32'hFFFFF020, v); chk("tcnt_4cyc", v, 1);
        tick(4);
        rd(32'hFFFFF020, v); chk("tcnt_8cyc", v, 2);

        // Wrap with TPRE=0
        io_wr(32'hFFFFF024, 0);
        io_wr(32'hFFFFF020, 32'hFFFFFFFF);
        rd(32'hFFFFF020, v); chk("tcnt_load", v, 32'hFFFFFFFF);
        tick(1);
        rd(32'hFFFFF020, v); chk("tcnt_wrap", v, 0);

        // Load coincident with an increment
        io_wr(32'hFFFFF020, 32'h100);
        rd(32'hFFFFF020, v); chk("tcnt_wr_wins", v, 32'h100);
        tick(1);
        rd(32'hFFFFF020, v); chk("tcnt_after_wr", v, 32'h101);

        // Display scan
        io_wr(32'hFFFFF000, 32'h76543210);
        prev = dig_en_o;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (dig_en_o == 8'hFE && prev != 8'hFE) found = 1'b1;
            else prev = dig_en_o;
        end
        chk("scan_sync", found, 1);
        for (int k = 0; k < 8; k++) begin
            ed = ~(8'd1 << k);
            for (int h = 0; h < 2; h++) begin
                chk($sformatf("dig%0d_%0d", k, h), dig_en_o, ed);
                chk($sformatf("seg%0d_%0d", k, h), seg_o, exp_seg[k]);
                tick(1);
            end
        end
        chk("dig_wrap", dig_en_o, 8'hFE);

        // Same-cycle read/write of DISP
        addr_i = 32'hFFFFF000; wdata_i = 32'h1; we_i = 1'b1;
        #1;
        chk("rw_old", rdata_o, 32'h76543210);
        tick(1);
        we_i = 1'b0;
        chk("rw_new", rdata_o, 32'h1);

        // Reset mid-run during an LED write, timer running
        addr_i = 32'hFFFFF060; wdata_i = 32'h00123456; we_i = 1'b1; rst = 1'b1;
        tick(1);
        we_i = 1'b0;
        chk("mrst_led", led_o, 0);
        chk("mrst_dig", dig_en_o, 8'hFF);
        chk("mrst_seg", seg_o, 8'hFF);
        rd(32'hFFFFF020, v); chk("mrst_tcnt", v, 0);
        addr_i = 32'h20; wdata_i = 32'hCAFEF00D; we_i = 1'b1;
        #1;
        chk("mrst_dram_we", dram_we_o, 0);
        tick(1);
        we_i = 1'b0; rst = 1'b0;
        tick(1);
        chk("mrst_next_dig", dig_en_o, 8'hFE);
        chk("mrst_next_seg", seg_o, 8'hC0);
        chk("mrst_next_led", led_o, 0);
        rd(32'hFFFFF020, v); chk("mrst_next_tcnt", v, 1);
        rd(32'hFFFFF000, v); chk("mrst_disp", v, 0);
        chk("mrst_dram_pulses", dram_pulses, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
